// File: rtl/count_wrap_monitor_if.sv
`default_nettype none
// ---- count_wrap_monitor_if : monitored-counter signals plus monitor status (rev 1.0) ----
// ---- master = stimulus/counter side, slave = monitor side ----
interface count_wrap_monitor_if #(
  parameter int CW = 4,
  parameter int WW = 8
);
  logic          load;
  logic          mode;
  logic [CW-1:0] data_in;
  logic [CW-1:0] count_in;
  logic          err_clr;
  logic          wrap_pulse;
  logic [WW-1:0] wrap_count;
  logic          illegal_err;
  logic          seq_err;
  logic          in_sync;

  modport master (
    output load, mode, data_in, count_in, err_clr,
    input  wrap_pulse, wrap_count, illegal_err, seq_err, in_sync
  );

  modport slave (
    input  load, mode, data_in, count_in, err_clr,
    output wrap_pulse, wrap_count, illegal_err, seq_err, in_sync
  );
endinterface
`default_nettype wire

// File: rtl/count_wrap_monitor.sv
`default_nettype none
// ---- count_wrap_monitor : wrap/sequence/range monitor for a mod-MOD up/down counter (rev 1.0) ----
// ---- Wrap accumulator present only when COUNT_WRAP_MON_CNT_EN is defined ----
module count_wrap_monitor #(
  parameter int MOD = 12,
  parameter int CW  = 4,
  parameter int WW  = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  count_wrap_monitor_if.slave mon
);
  localparam logic [CW:0] c_mod      = (CW+1)'(MOD);
  localparam logic [CW:0] c_mod_last = (CW+1)'(MOD - 1);
  localparam logic [CW:0] c_one      = (CW+1)'(1);

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] prev_cnt_q, prev_data_q;
  logic          prev_load_q, prev_mode_q;
  logic          wrap_pulse_q;
  logic          illegal_q, illegal_d;
  logic          seq_q, seq_d;

  logic [CW:0]   w_cnt, w_prev, w_pred;
  logic          w_mismatch, w_wrap_hit;

  // One spare bit so prev+1 from an out-of-range value cannot alias a legal count
  assign w_cnt  = {1'b0, mon.count_in};
  assign w_prev = {1'b0, prev_cnt_q};

  always_comb begin
    w_pred = w_prev;
    if (prev_load_q) begin
      w_pred = {1'b0, prev_data_q};
    end else if (prev_mode_q) begin
      w_pred = (w_prev == c_mod_last) ? '0 : w_prev + c_one;
    end else begin
      w_pred = (w_prev == '0) ? c_mod_last : w_prev - c_one;
    end
  end

  assign w_mismatch = (w_cnt != w_pred);
  assign w_wrap_hit = (state_q == S_TRACK) && !prev_load_q &&
                      (( prev_mode_q && (w_prev == c_mod_last) && (w_cnt == '0)) ||
                       (!prev_mode_q && (w_prev == '0) && (w_cnt == c_mod_last)));

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    illegal_d = illegal_q;
    case (state_q)
      S_SYNC:  state_d = S_TRACK;
      S_TRACK: begin
        if (w_mismatch) begin
          seq_d   = 1'b1;
          state_d = S_ERROR;
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_SYNC;
    endcase
    if (mon.err_clr) begin
      seq_d     = 1'b0;
      illegal_d = 1'b0;
      state_d   = S_SYNC;
    end
    // Range check follows the clear so a simultaneous new violation stays flagged
    if (w_cnt >= c_mod) begin
      illegal_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_SYNC;
      prev_cnt_q   <= '0;
      prev_data_q  <= '0;
      prev_load_q  <= 1'b0;
      prev_mode_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      illegal_q    <= 1'b0;
      seq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_cnt_q   <= mon.count_in;
      prev_data_q  <= mon.data_in;
      prev_load_q  <= mon.load;
      prev_mode_q  <= mon.mode;
      wrap_pulse_q <= w_wrap_hit;
      illegal_q    <= illegal_d;
      seq_q        <= seq_d;
    end
  end

`ifdef COUNT_WRAP_MON_CNT_EN
  logic [WW-1:0] wrap_count_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wrap_count_q <= '0;
    end else if (w_wrap_hit && (wrap_count_q != '1)) begin
      wrap_count_q <= wrap_count_q + WW'(1);
    end
  end

  assign mon.wrap_count = wrap_count_q;
`else
  assign mon.wrap_count = {WW{1'b0}};
`endif

  assign mon.wrap_pulse  = wrap_pulse_q;
  assign mon.illegal_err = illegal_q;
  assign mon.seq_err     = seq_q;
  assign mon.in_sync     = (state_q == S_TRACK);
endmodule
`default_nettype wire
